// File: rtl/nand_cpu_pkg.sv
// Shared fetch-side types: BTB entry layout, counter constants and
// the 2-bit saturating counter helpers.
package nand_cpu_pkg;
    localparam int PC_SIZE      = 16;
    localparam int BTB_IDX_SIZE = 3;
    localparam int BTB_TAG_SIZE = PC_SIZE - BTB_IDX_SIZE;

    localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_SIZE-1:0] tag;
        logic [PC_SIZE-1:0]      target;
        logic [1:0]              ctr;
    } btb_entry_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction
endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup port and a
// single clocked update port driven by decode feedback.
module fetch_btb
    import nand_cpu_pkg::*;
#(
    parameter int PC_W      = PC_SIZE,
    parameter int BTB_IDX_W = BTB_IDX_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            predict_taken,
    output logic [PC_W-1:0] predict_target,
    input  logic            upd_valid,
    input  logic            upd_branch,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target
);
    localparam int ENTRIES = 1 << BTB_IDX_W;

    btb_entry_t mem [ENTRIES];

    btb_entry_t             lk;
    logic                   lk_hit;
    btb_entry_t             up;
    logic                   up_hit;
    logic [BTB_IDX_W-1:0]   up_idx;

    // Lookup reads the array before this edge's update lands: no bypass.
    assign lk             = mem[lookup_pc[BTB_IDX_W-1:0]];
    assign lk_hit         = lk.valid && (lk.tag == lookup_pc[PC_W-1:BTB_IDX_W]);
    assign predict_taken  = lk_hit & lk.ctr[1];
    assign predict_target = lk_hit ? lk.target : '0;

    assign up_idx = upd_pc[BTB_IDX_W-1:0];
    assign up     = mem[up_idx];
    assign up_hit = up.valid && (up.tag == upd_pc[PC_W-1:BTB_IDX_W]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
        end else if (upd_valid) begin
            if (upd_branch && upd_taken) begin
                if (up_hit) begin
                    mem[up_idx].ctr    <= sat_inc(up.ctr);
                    mem[up_idx].target <= upd_target;
                end else begin
                    mem[up_idx] <= '{valid: 1'b1, tag: upd_pc[PC_W-1:BTB_IDX_W],
                                     target: upd_target, ctr: CTR_WEAK_TAKEN};
                end
            end else if (upd_branch) begin
                if (up_hit) mem[up_idx].ctr <= sat_dec(up.ctr);
            end else if (up_hit) begin
                // A non-branch matching an entry means the entry is stale.
                mem[up_idx].valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register with BTB prediction, mispredict detection from decode
// feedback and the prioritised next-PC select.
module fetch_pc_unit
    import nand_cpu_pkg::*;
#(
    parameter int              PC_W      = PC_SIZE,
    parameter int              BTB_IDX_W = BTB_IDX_SIZE,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_stall,
    input  logic            i_fb_valid,
    input  logic            i_fb_branch,
    input  logic [PC_W-1:0] i_fb_pc,
    input  logic            i_fb_predict_taken,
    input  logic [PC_W-1:0] i_fb_predict_target,
    input  logic            i_fb_feedback_taken,
    input  logic [PC_W-1:0] i_fb_feedback_target,
    output logic [PC_W-1:0] o_pc,
    output logic            o_valid,
    output logic            o_predict_taken,
    output logic [PC_W-1:0] o_predict_target,
    output logic            o_flush
);
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic            actual_taken;
    logic            mispred;

    fetch_btb #(.PC_W(PC_W), .BTB_IDX_W(BTB_IDX_W)) u_btb (
        .clk            (clk),
        .rst            (rst),
        .lookup_pc      (pc),
        .predict_taken  (o_predict_taken),
        .predict_target (o_predict_target),
        .upd_valid      (i_fb_valid),
        .upd_branch     (i_fb_branch),
        .upd_taken      (i_fb_feedback_taken),
        .upd_pc         (i_fb_pc),
        .upd_target     (i_fb_feedback_target)
    );

    // Wrong direction, or right "taken" direction with the wrong target.
    assign actual_taken = i_fb_branch & i_fb_feedback_taken;
    assign mispred = i_fb_valid &
                     ((i_fb_predict_taken != actual_taken) |
                      (actual_taken & i_fb_predict_taken &
                       (i_fb_predict_target != i_fb_feedback_target)));

    assign o_pc    = pc;
    assign o_flush = mispred & ~rst;
    assign o_valid = ~rst & ~mispred;

    always_comb begin
        next_pc = pc + 1'b1;
        if (mispred)              next_pc = actual_taken ? i_fb_feedback_target : i_fb_pc + 1'b1;
        else if (i_stall)         next_pc = pc;
        else if (o_predict_taken) next_pc = o_predict_target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= RESET_PC;
        else     pc <= next_pc;
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized feedback,
// all checked against a behavioural PC/BTB model.
module tb_fetch_pc_unit;
    logic        clk = 1'b0;
    logic        rst, stall, fbv, fbb, fbpt, fbtk;
    logic [15:0] fbpc, fbptg, fbtg;
    logic [15:0] o_pc, o_predict_target;
    logic        o_valid, o_predict_taken, o_flush;

    int vectors = 0, miscompares = 0;

    fetch_pc_unit dut (
        .clk(clk), .rst(rst), .i_stall(stall), .i_fb_valid(fbv), .i_fb_branch(fbb),
        .i_fb_pc(fbpc), .i_fb_predict_taken(fbpt), .i_fb_predict_target(fbptg),
        .i_fb_feedback_taken(fbtk), .i_fb_feedback_target(fbtg),
        .o_pc(o_pc), .o_valid(o_valid), .o_predict_taken(o_predict_taken),
        .o_predict_target(o_predict_target), .o_flush(o_flush)
    );

    always #5 clk = ~clk;

    // Reference model: 8 BTB slots kept as plain integers.
    int  m_pc;
    bit  mv [8];
    int  mt [8], mtg [8], mc [8];
    bit  exp_pt, exp_flush, exp_valid;
    int  exp_tgt;

    function automatic void model_reset();
        m_pc = 0;
        for (int i = 0; i < 8; i++) begin mv[i] = 0; mt[i] = 0; mtg[i] = 0; mc[i] = 0; end
    endfunction

    function automatic void model_comb();
        int  idx = m_pc % 8;
        bit  hit = mv[idx] && (mt[idx] == m_pc / 8);
        bit  act = fbb && fbtk;
        exp_pt    = hit && (mc[idx] >= 2);
        exp_tgt   = hit ? mtg[idx] : 0;
        exp_flush = !rst && fbv && ((fbpt != act) || (act && fbpt && (fbptg != fbtg)));
        exp_valid = !rst && !exp_flush;
    endfunction

    function automatic void model_commit();
        int i = fbpc % 8;
        int t = fbpc / 8;
        bit h = mv[i] && (mt[i] == t);
        if (rst) begin model_reset(); return; end
        if (exp_flush)       m_pc = (fbb && fbtk) ? int'(fbtg) : (int'(fbpc) + 1) % 65536;
        else if (stall)      m_pc = m_pc;
        else if (exp_pt)     m_pc = exp_tgt;
        else                 m_pc = (m_pc + 1) % 65536;
        if (fbv) begin
            if (fbb && fbtk) begin
                if (h) begin mc[i] = (mc[i] < 3) ? mc[i] + 1 : 3; mtg[i] = fbtg; end
                else begin mv[i] = 1; mt[i] = t; mtg[i] = fbtg; mc[i] = 2; end
            end else if (fbb) begin
                if (h) mc[i] = (mc[i] > 0) ? mc[i] - 1 : 0;
            end else if (h) mv[i] = 0;
        end
    endfunction

    task automatic drive(input bit st, input bit v, input bit br, input logic [15:0] p,
                         input bit pt, input logic [15:0] ptg, input bit tk, input logic [15:0] tg);
        stall = st; fbv = v; fbb = br; fbpc = p; fbpt = pt; fbptg = ptg; fbtk = tk; fbtg = tg;
        #1 model_comb();
    endtask

    task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic tick();
        @(posedge clk); model_commit();
        @(negedge clk);
    endtask

    // Steer fetch to addr via a "predicted taken, actually non-branch" feedback.
    task automatic redirect_to(input logic [15:0] addr);
        drive(0, 1, 0, addr - 16'd1, 1, 16'h0, 0, 16'h0);
        tick(); idle();
    endtask

    task automatic test_reset();
        rst = 1; idle(); model_reset();
        tick(); tick();
        rst = 0; idle();
        drive(0, 1, 1, 16'h0100, 0, 16'h0, 1, 16'h0042);
        tick(); idle();
        vectors++;
        if (o_pc !== 16'h0042) begin miscompares++; $display("FAIL reset_pre pc got %h want 0042", o_pc); end
        #2 rst = 1;
        #1; vectors++;
        if (o_pc !== 16'h0 || o_valid !== 1'b0 || o_flush !== 1'b0 || o_predict_taken !== 1'b0 || o_predict_target !== 16'h0) begin
            miscompares++; $display("FAIL reset_async pc=%h valid=%b flush=%b pt=%b tgt=%h want 0000/0/0/0/0",
                                    o_pc, o_valid, o_flush, o_predict_taken, o_predict_target);
        end
        tick(); rst = 0; idle();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (o_pc !== 16'(k) || o_valid !== 1'b1 || o_predict_taken !== 1'b0) begin
                miscompares++; $display("FAIL reset_seq%0d pc=%h valid=%b pt=%b want %h/1/0", k, o_pc, o_valid, o_predict_taken, 16'(k));
            end
            tick(); idle();
        end
    endtask

    task automatic test_stall();
        redirect_to(16'd5);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0);
            vectors++;
            if (o_pc !== 16'd5 || o_valid !== 1'b1) begin
                miscompares++; $display("FAIL stall_hold%0d pc got %h want 0005", k, o_pc);
            end
            tick();
        end
        idle(); tick(); vectors++;
        if (o_pc !== 16'd6) begin miscompares++; $display("FAIL stall_release pc got %h want 0006", o_pc); end
    endtask

    task automatic test_branch_learn();
        drive(0, 1, 1, 16'h0004, 0, 16'h0, 1, 16'h0020);
        vectors++;
        if (o_flush !== 1'b1 || o_valid !== 1'b0) begin
            miscompares++; $display("FAIL learn_flush flush=%b valid=%b want 1/0", o_flush, o_valid);
        end
        tick(); idle(); vectors++;
        if (o_pc !== 16'h0020) begin miscompares++; $display("FAIL learn_redirect pc got %h want 0020", o_pc); end
        redirect_to(16'h0004); vectors++;
        if (o_pc !== 16'h0004 || o_predict_taken !== 1'b1 || o_predict_target !== 16'h0020) begin
            miscompares++; $display("FAIL learn_predict pc=%h pt=%b tgt=%h want 0004/1/0020", o_pc, o_predict_taken, o_predict_target);
        end
        tick(); idle(); vectors++;
        if (o_pc !== 16'h0020) begin miscompares++; $display("FAIL learn_follow pc got %h want 0020", o_pc); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 16'h0004, 1, 16'h0020, 1, 16'h0020);
            vectors++;
            if (o_flush !== 1'b0) begin miscompares++; $display("FAIL sat_taken%0d flush got %b want 0", k, o_flush); end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 1, 16'h0004, 1, 16'h0020, 0, 16'h0);
            vectors++;
            if (o_flush !== 1'b1) begin miscompares++; $display("FAIL sat_nt%0d flush got %b want 1", k, o_flush); end
            tick(); idle();
            redirect_to(16'h0004); vectors++;
            if (o_predict_taken !== (k == 0)) begin
                miscompares++; $display("FAIL sat_pred%0d pt got %b want %b", k, o_predict_taken, k == 0);
            end
        end
    endtask

    task automatic test_redirect_stall();
        drive(1, 1, 1, 16'h0009, 1, 16'h0050, 0, 16'h0);
        vectors++;
        if (o_flush !== 1'b1 || o_valid !== 1'b0) begin
            miscompares++; $display("FAIL rs_flush flush=%b valid=%b want 1/0", o_flush, o_valid);
        end
        tick(); idle(); vectors++;
        if (o_pc !== 16'h000A) begin miscompares++; $display("FAIL rs_pc pc got %h want 000a", o_pc); end
    endtask

    task automatic test_wrap_alias();
        redirect_to(16'hFFFF); vectors++;
        if (o_pc !== 16'hFFFF || o_predict_taken !== 1'b0) begin
            miscompares++; $display("FAIL wrap_at pc=%h pt=%b want ffff/0", o_pc, o_predict_taken);
        end
        tick(); idle(); vectors++;
        if (o_pc !== 16'h0000) begin miscompares++; $display("FAIL wrap_pc pc got %h want 0000", o_pc); end
        drive(0, 1, 1, 16'h000C, 0, 16'h0, 1, 16'h0030);
        tick(); idle();
        redirect_to(16'h000C);
        drive(0, 1, 0, 16'h000C, 1, 16'h0030, 0, 16'h0);
        vectors++;
        if (o_flush !== 1'b1) begin miscompares++; $display("FAIL alias_flush flush got %b want 1", o_flush); end
        tick(); idle(); vectors++;
        if (o_pc !== 16'h000D) begin miscompares++; $display("FAIL alias_pc pc got %h want 000d", o_pc); end
        redirect_to(16'h000C); vectors++;
        if (o_predict_taken !== 1'b0 || o_predict_target !== 16'h0) begin
            miscompares++; $display("FAIL alias_inval pt=%b tgt=%h want 0/0000", o_predict_taken, o_predict_target);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic [15:0] p, tg, ptg;
            bit          pt, tk;
            p   = 16'($urandom_range(0, 31));
            tg  = 16'($urandom_range(0, 31));
            pt  = bit'($urandom_range(0, 1));
            tk  = bit'($urandom_range(0, 1));
            ptg = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 31)) : tg;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                  p, pt, ptg, tk, tg);
            vectors++;
            if (o_pc !== 16'(m_pc) || o_valid !== exp_valid || o_flush !== exp_flush ||
                o_predict_taken !== exp_pt || o_predict_target !== 16'(exp_tgt)) begin
                miscompares++;
                $display("FAIL rand%0d pc=%h valid=%b flush=%b pt=%b tgt=%h want %h/%b/%b/%b/%h", k,
                         o_pc, o_valid, o_flush, o_predict_taken, o_predict_target,
                         16'(m_pc), exp_valid, exp_flush, exp_pt, 16'(exp_tgt));
            end
            tick();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stall();
        test_branch_learn();
        test_saturation();
        test_redirect_stall();
        test_wrap_alias();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Owns the architectural fetch PC and produces the next fetch address for the fetch stage each cycle.
- Predicts branches with a small direct-mapped branch target buffer (BTB). Each entry holds a tag, a target and a 2-bit saturating counter.
- Consumes the branch feedback produced in decode. On a misprediction it redirects the PC and flushes the wrong-path fetch.
- Sits directly upstream of the fetch stage; its o_pc drives the fetch-stage PC input.

Parameters:
- PC_W, `PC_SIZE, width of the PC and of branch targets.
- BTB_IDX_W, 3, log2 of the BTB entry count (8 entries).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_stall  in  1  downstream stall; hold the PC.
- i_fb_valid  in  1  feedback entry valid this cycle.
- i_fb_branch  in  1  the fed-back instruction is a branch.
- i_fb_pc  in  PC_W  PC of the fed-back instruction.
- i_fb_predict_taken  in  1  prediction made at fetch for that instruction.
- i_fb_predict_target  in  PC_W  target predicted at fetch.
- i_fb_feedback_taken  in  1  resolved direction.
- i_fb_feedback_target  in  PC_W  resolved target.
- o_pc  out  PC_W  current fetch PC (registered).
- o_valid  out  1  o_pc is a valid, non-flushed fetch.
- o_predict_taken  out  1  BTB prediction for o_pc.
- o_predict_target  out  PC_W  predicted target for o_pc.
- o_flush  out  1  misprediction redirect this cycle; younger stages squash.

Behaviour:
- **Reset (async, while rst=1):**
  - pc=RESET_PC; all BTB valid bits=0.
  - o_valid=0, o_flush=0, o_predict_taken=0, o_predict_target=0.
- **Lookup (combinational on o_pc):**
  - idx = o_pc[BTB_IDX_W-1:0]; tag = o_pc[PC_W-1:BTB_IDX_W].
  - hit = valid[idx] & tag match.
  - o_predict_taken = hit & ctr[idx][1].
  - o_predict_target = hit ? target[idx] : 0.
- **Mispredict (combinational):**
  - mispred = i_fb_valid & (i_fb_predict_taken != (i_fb_branch & i_fb_feedback_taken) | (i_fb_branch & i_fb_feedback_taken & i_fb_predict_taken & i_fb_predict_target != i_fb_feedback_target)).
  - o_flush = mispred.
  - o_valid = !rst & !mispred.
- **Next PC, priority order:**
  1. mispred: pc <= (i_fb_branch & i_fb_feedback_taken) ? i_fb_feedback_target : i_fb_pc+1.
  2. i_stall: hold.
  3. o_predict_taken: pc <= o_predict_target.
  4. Otherwise: pc <= o_pc+1.
- **Next-PC rules:**
  - Redirect overrides stall.
  - PC+1 wraps modulo 2^PC_W (all-ones -> 0).
  - Latency: redirected PC appears on o_pc the cycle after o_flush.
- **BTB update (on edge, when i_fb_valid; independent of stall):**
  - Index and tag are taken from i_fb_pc.
  - Branch taken, hit: ctr = sat_inc(ctr); target = i_fb_feedback_target.
  - Branch taken, miss: allocate or replace; valid=1, tag, target, ctr=2'b10.
  - Branch not taken, hit: ctr = sat_dec(ctr).
  - Branch not taken, miss: no change.
  - Non-branch, hit: clear valid (alias removal).
  - Counters saturate at 2'b11 and 2'b00.
- **Simultaneous events:**
  - Lookup and update to the same index in the same cycle: lookup sees pre-update contents (no bypass).
  - Update and redirect in the same cycle both take effect.
- **Reset mid-operation:** all state clears immediately. The first post-reset fetch is RESET_PC with o_valid=1.

Decomposition:
- Shared package (nand_cpu_pkg) holds:
  - btb_entry_t struct {valid, tag, target, ctr[1:0]};
  - CTR_WEAK_TAKEN = 2'b10;
  - sat_inc and sat_dec functions.
- Sub-module fetch_btb (storage, lookup port, update port).
- fetch_pc_unit holds the PC register, mispredict detection and next-PC mux.

Test Plan:
- Reset: rst=1 mid-run with pc=0x0042 -> o_pc=0x0000 and o_valid=0 immediately; after release, o_pc sequence 0,1,2,3 with o_predict_taken=0.
- Stall: i_stall=1 for 3 cycles at pc=5 -> o_pc holds 5. Release -> 6.
- Taken-branch learning:
  - Feedback pc=4, branch, taken to 0x20, predicted not taken -> o_flush=1, next o_pc=0x20, BTB[4] ctr=10.
  - Refetch of 4 -> o_predict_taken=1, target 0x20, next o_pc=0x20.
- Counter saturation: four taken feedbacks at pc=4 -> ctr=11. One not-taken -> ctr=10, still predicts taken. Second not-taken -> 01, predicts not taken.
- Redirect vs stall: i_stall=1 with mispredict at pc=9, resolved not taken, predicted taken -> o_flush=1, o_valid=0, next o_pc=10.
- Wrap and alias:
  - pc=all-ones, no hit -> next o_pc=0.
  - Non-branch feedback at pc=0x0C hitting a stale entry with predict_taken=1 -> flush to 0x0D, entry invalidated.
